// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: assembles a DIM x DIM matrix of ELEM_W-bit elements from
// an element stream (valid/ready) into the flat packed format used by the MPU
// operation stages, then hands the finished matrix off over valid/ready.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush of a partial or held matrix
//   in_data      next element; in_valid/in_ready handshake
//   matrix       assembled matrix, element k at [ELEM_W*k +: ELEM_W]
//   out_valid    matrix complete; out_ready accepts it
//   elem_count   elements stored in the current matrix (0..DIM*DIM)
module mpu_matrix_loader #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [ELEM_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [ELEM_W*DIM*DIM-1:0]         matrix,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(DIM*DIM+1)-1:0]      elem_count
);

    localparam int unsigned N_ELEM = DIM * DIM;
    localparam int unsigned MAT_W  = ELEM_W * N_ELEM;
    localparam int unsigned CNT_W  = $clog2(N_ELEM + 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [MAT_W-1:0]   r_matrix;
    logic               w_in_fire;
    logic               w_wr_en;

    // Handshake flags are a pure decode of the state register.
    assign in_ready   = (r_state == ST_LOAD);
    assign out_valid  = (r_state == ST_FULL);
    assign matrix     = r_matrix;
    assign elem_count = r_count;

    // State and element counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic; clear overrides any transfer in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_in_fire   = in_valid && (r_state == ST_LOAD);
        w_wr_en     = w_in_fire && !clear;
        if (clear) begin
            w_state_nxt = ST_LOAD;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        w_count_nxt = r_count + CNT_W'(1);
                        if (r_count == CNT_W'(N_ELEM - 1)) begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_state_nxt = ST_LOAD;
                        w_count_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // Matrix storage: the accepted element lands in the slot selected by the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_matrix <= '0;
        end else if (w_wr_en) begin
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                if (r_count == CNT_W'(k)) begin
                    r_matrix[k*ELEM_W +: ELEM_W] <= in_data;
                end
            end
        end
    end

endmodule
